rpi_irq_scheduler: RTL
======================

RPI_IRQ_SCHEDULER -- requirements
Module: rpi_irq_scheduler

Interface
REQ-001 SHALL have parameter DIV_MAX, default 66666: tick period is DIV_MAX+1 clk_in cycles.
REQ-002 SHALL have parameter TIMEOUT, default 50000: clk_in cycles irq_out may stay high without an ack.
REQ-003 SHALL have parameter HOLDOFF, default 16: clk_in cycles irq_out is forced low after each interrupt.
REQ-004 SHALL have port clk_in, input, 1 bit: sole clock, 50 MHz.
REQ-005 SHALL have port reset, input, 1 bit: asynchronous, active-high reset.
REQ-006 SHALL have port interrupt_enable, input, 1 bit: level enable for interrupt generation, synchronous to clk_in.
REQ-007 SHALL have port data_ready, input, 1 bit: single-cycle pulse meaning one audio block is ready for the RPi.
REQ-008 SHALL have port rpi_ack, input, 1 bit: asynchronous RPi GPIO; a rising edge acknowledges the current interrupt.
REQ-009 SHALL have port irq_out, output, 1 bit: interrupt line to the RPi, active-high level.
REQ-010 SHALL have port pending, output, 8 bits: count of unserviced data_ready events.
REQ-011 SHALL have port overrun, output, 1 bit: sticky error flag.
REQ-012 SHALL have port busy, output, 1 bit: high whenever the FSM is not in IDLE.

Function
REQ-013 SHALL use a free-running 17-bit divider counting 0..DIV_MAX, independent of interrupt_enable.
REQ-014 SHALL assert tick for exactly one cycle when the divider equals DIV_MAX; the divider wraps to 0 on the next edge.
REQ-015 SHALL pass rpi_ack through a 2-flop synchronizer followed by a rising-edge detector, giving ack_evt.
REQ-016 SHALL increment pending on data_ready.
REQ-017 SHALL decrement pending on an accepted ack (REQ-021).
REQ-018 SHALL leave pending unchanged when data_ready and an accepted ack occur in the same cycle.
REQ-019 SHALL saturate pending at 255; a data_ready arriving at 255 sets overrun and leaves pending at 255.
REQ-020 SHALL implement states IDLE, WAIT_ACK and HOLDOFF; irq_out is high only in WAIT_ACK and is registered.
REQ-021 SHALL move IDLE->WAIT_ACK when interrupt_enable=1, pending!=0 and tick=1 in the same cycle; irq_out is high from the next edge and the timeout timer clears.
REQ-022 SHALL, in WAIT_ACK, treat ack_evt as an accepted ack: decrement pending, drive irq_out low, go to HOLDOFF.
REQ-023 SHALL make irq_out fall no more than 3 clk_in cycles after an rpi_ack rising edge.
REQ-024 SHALL, in WAIT_ACK, when the timer reaches TIMEOUT cycles: drive irq_out low, set overrun, leave pending unchanged, go to HOLDOFF.
REQ-025 SHALL ignore ack_evt in IDLE and HOLDOFF, with no change to pending.
REQ-026 SHALL count HOLDOFF cycles in HOLDOFF, then go to IDLE; the next interrupt waits for a subsequent tick.
REQ-027 SHALL, when interrupt_enable=0 in any state: go to IDLE on the next edge, drive irq_out to 0 and clear the timers; pending keeps counting data_ready.
REQ-028 SHALL set overrun only; overrun is cleared only by reset.

Reset
REQ-029 SHALL, while reset=1 and regardless of clk_in: state=IDLE, irq_out=0, pending=0, overrun=0, busy=0, divider=0, synchronizer flops=0, timers=0.
REQ-030 SHALL resume normal operation on the first clk_in edge after reset is released; reset in mid-WAIT_ACK drops irq_out immediately.

Verification (DIV_MAX=9, TIMEOUT=20, HOLDOFF=4)
REQ-031 SHALL cover: one data_ready with enable=1 -> irq_out rises the edge after divider==9; ack edge -> irq_out low within 3 cycles, pending=0, no further irq.
REQ-032 SHALL cover: pending=1 and no ack -> irq_out high exactly 20 cycles, then low, overrun=1, pending=1; irq re-asserts after the first tick following 4 holdoff cycles.
REQ-033 SHALL cover: 256 data_ready pulses with enable=0 -> pending=255, overrun=1, irq_out=0 throughout.
REQ-034 SHALL cover: pending=2 in WAIT_ACK, data_ready coinciding with ack_evt -> pending stays 2, state HOLDOFF.
REQ-035 SHALL cover: enable dropped during WAIT_ACK -> irq_out=0 and busy=0 on the next edge, pending unchanged.
REQ-036 SHALL cover: reset asserted during WAIT_ACK with pending=3 -> irq_out, pending, overrun and busy all 0 before the next clk_in edge.

Source files
------------

// File: rtl/rpi_irq_scheduler.sv
// rpi_irq_scheduler: tick-paced RPi interrupt generator with ack handshake, pending count and overrun flag
module rpi_irq_scheduler #(
  parameter int DIV_MAX = 66666,
  parameter int TIMEOUT = 50000,
  parameter int HOLDOFF = 16
) (
  input  logic       clk_in,
  input  logic       reset,
  input  logic       interrupt_enable,
  input  logic       data_ready,
  input  logic       rpi_ack,
  output logic       irq_out,
  output logic [7:0] pending,
  output logic       overrun,
  output logic       busy
);
  localparam logic [1:0] S_IDLE = 2'd0, S_WAIT = 2'd1, S_HOLD = 2'd2;
  localparam int TW = $clog2(TIMEOUT + 1);
  localparam int HW = $clog2(HOLDOFF + 1);
  logic [16:0]   r_div;
  logic [2:0]    r_ack;
  logic [1:0]    r_state;
  logic          r_irq;
  logic [TW-1:0] r_tmr;
  logic [HW-1:0] r_hold;
  logic [7:0]    r_pend;
  logic          r_ovr;
  logic          w_tick, w_ack_evt, w_acc, w_tmo, w_start, w_hold_done;
  assign w_tick      = r_div == 17'(DIV_MAX);
  assign w_ack_evt   = r_ack[1] & ~r_ack[2];
  assign w_acc       = interrupt_enable && r_state == S_WAIT && w_ack_evt;
  assign w_tmo       = interrupt_enable && r_state == S_WAIT && !w_ack_evt && r_tmr == TW'(TIMEOUT - 1);
  assign w_start     = r_state == S_IDLE && r_pend != 8'd0 && w_tick;
  assign w_hold_done = r_hold == HW'(HOLDOFF - 1);
  assign irq_out = r_irq;
  assign pending = r_pend;
  assign overrun = r_ovr;
  assign busy    = r_state != S_IDLE;
  // free-running divider producing a one-cycle tick every DIV_MAX+1 cycles
  always_ff @(posedge clk_in or posedge reset)
    if (reset) r_div <= '0;
    else r_div <= w_tick ? '0 : r_div + 17'd1;
  // two-flop synchronizer for rpi_ack plus one extra flop for rising-edge detection
  always_ff @(posedge clk_in or posedge reset)
    if (reset) r_ack <= '0;
    else r_ack <= {r_ack[1:0], rpi_ack};
  // interrupt FSM; an ack wins over a timeout landing in the same cycle
  always_ff @(posedge clk_in or posedge reset)
    if (reset || !interrupt_enable) begin
      r_state <= S_IDLE;
      r_irq   <= 1'b0;
      r_tmr   <= '0;
      r_hold  <= '0;
    end else begin
      case (r_state)
        S_IDLE: if (w_start) begin
          r_state <= S_WAIT;
          r_irq   <= 1'b1;
          r_tmr   <= '0;
        end
        S_WAIT: if (w_ack_evt || w_tmo) begin
          r_state <= S_HOLD;
          r_irq   <= 1'b0;
          r_hold  <= '0;
        end else r_tmr <= r_tmr + TW'(1);
        S_HOLD: if (w_hold_done) r_state <= S_IDLE;
        else r_hold <= r_hold + HW'(1);
        default: r_state <= S_IDLE;
      endcase
    end
  // saturating pending counter and sticky overrun flag
  always_ff @(posedge clk_in or posedge reset)
    if (reset) begin
      r_pend <= '0;
      r_ovr  <= 1'b0;
    end else begin
      if (data_ready && !w_acc && r_pend != 8'hFF) r_pend <= r_pend + 8'd1;
      else if (w_acc && !data_ready) r_pend <= r_pend - 8'd1;
      if (w_tmo || (data_ready && !w_acc && r_pend == 8'hFF)) r_ovr <= 1'b1;
    end
endmodule
